// File: rtl/inst_req_stage.sv
// inst_req_stage: PC owner and single-outstanding instruction requester for the fetch stage.
// Redirects cancel in-flight work; a pending branch takes effect after its delay slot.
module inst_req_stage #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        stop,
   input  logic        exception,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_req_addr,
   input  logic        inst_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        inst_data_ok,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, req_pc, req_pc_n, br_tgt, br_tgt_n;
   logic [31:0] buf_addr, buf_addr_n, buf_data, buf_data_n;
   logic cancel, cancel_n, br_pend, br_pend_n, held, held_n;
   logic redirect;
   logic [31:0] target;
   assign redirect = exception | eret;
   assign target = exception ? EXC_PC : epc;
   assign inst_wr = 1'b0;
   assign inst_size = 2'b10;
   assign inst_req = state == REQ && !stop;
   assign inst_req_addr = pc;
   assign inst_data_ok = state == DONE && !stall && !stop && !redirect;
   assign inst_addr = state == DONE ? buf_addr : 32'h0;
   assign inst_rdata = state == DONE ? buf_data : 32'h0;
   always_comb begin
      state_n = state;
      pc_n = pc;
      req_pc_n = req_pc;
      br_tgt_n = br_tgt;
      br_pend_n = br_pend;
      cancel_n = cancel;
      held_n = held;
      buf_addr_n = buf_addr;
      buf_data_n = buf_data;
      if (!stop) begin
         if (br_taken) begin
            br_pend_n = 1'b1;
            br_tgt_n = br_target;
         end
         if (redirect) begin
            pc_n = target;
            br_pend_n = 1'b0;
         end
         case (state)
            IDLE: state_n = REQ;
            REQ: if (inst_addr_ok) begin
               state_n = WAIT;
               req_pc_n = pc;
               cancel_n = redirect;
            end
            WAIT: if (mem_data_ok || held) begin
               held_n = 1'b0;
               cancel_n = 1'b0;
               state_n = (cancel || redirect) ? REQ : DONE;
               buf_addr_n = req_pc;
               buf_data_n = mem_data_ok ? mem_rdata : buf_data;
            end else if (redirect) cancel_n = 1'b1;
            DONE: if (redirect) state_n = REQ;
            else if (!stall) begin
               pc_n = br_pend_n ? br_tgt_n : req_pc + 32'd4;
               br_pend_n = 1'b0;
               state_n = REQ;
            end
         endcase
      end else if (state == WAIT && mem_data_ok) begin
         // frozen: park the response so it survives until the stop lifts
         buf_addr_n = req_pc;
         buf_data_n = mem_rdata;
         held_n = 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         req_pc <= 32'h0;
         br_tgt <= 32'h0;
         br_pend <= 1'b0;
         cancel <= 1'b0;
         held <= 1'b0;
         buf_addr <= 32'h0;
         buf_data <= 32'h0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         req_pc <= req_pc_n;
         br_tgt <= br_tgt_n;
         br_pend <= br_pend_n;
         cancel <= cancel_n;
         held <= held_n;
         buf_addr <= buf_addr_n;
         buf_data <= buf_data_n;
      end
   end
endmodule

// File: tb/tb_inst_req_stage.sv
// tb_inst_req_stage: directed and random checks against an instruction-stream reference model.
module tb_inst_req_stage;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;
   localparam logic [31:0] EXC_PC   = 32'hbfc00380;
   logic clk = 1'b0;
   logic reset, stall, stop, exception, eret, br_taken, inst_addr_ok, mem_data_ok;
   logic [31:0] epc, br_target, mem_rdata;
   logic inst_req, inst_wr, inst_data_ok;
   logic [1:0] inst_size;
   logic [31:0] inst_req_addr, inst_addr, inst_rdata;
   int vectors = 0, errs = 0, cyc = 0;
   int ok_pct = 100, lat_min = 0, lat_max = 0, lat = 0;
   logic pend = 1'b0, armed = 1'b0;
   logic [31:0] pend_addr = 32'h0, exp_pc = RESET_PC, tgt = 32'h0;
   logic [31:0] got_q[$], acc_q[$];
   int dok_cyc[$], acc_cyc[$];
   inst_req_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .stop(stop), .exception(exception), .eret(eret),
      .epc(epc), .br_taken(br_taken), .br_target(br_target), .inst_req(inst_req), .inst_wr(inst_wr),
      .inst_size(inst_size), .inst_req_addr(inst_req_addr), .inst_addr_ok(inst_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .inst_data_ok(inst_data_ok),
      .inst_addr(inst_addr), .inst_rdata(inst_rdata)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a == RESET_PC ? 32'h24080001 : (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      logic redir;
      mem_data_ok = pend && lat == 0;
      mem_rdata = mem_data_ok ? memf(pend_addr) : $urandom;
      inst_addr_ok = $urandom_range(99) < ok_pct;
      @(negedge clk);
      redir = exception | eret;
      if (reset) begin
         check("rst_req", inst_req, 0);
         check("rst_dok", inst_data_ok, 0);
         check("rst_addr", inst_addr, 0);
         check("rst_rdata", inst_rdata, 0);
         check("rst_pc", inst_req_addr, RESET_PC);
         exp_pc = RESET_PC;
         armed = 1'b0;
      end else begin
         check("tie", {inst_wr, inst_size}, 3'b010);
         if (stop) check("stop_req", inst_req, 0);
         if (inst_req) begin
            check("req_addr", inst_req_addr, exp_pc);
            check("one_outstanding", pend, 0);
         end
         if (stall || stop || redir) check("dok_gate", inst_data_ok, 0);
         if (inst_data_ok) begin
            check("dok_addr", inst_addr, exp_pc);
            check("dok_rdata", inst_rdata, memf(exp_pc));
            got_q.push_back(inst_addr);
            dok_cyc.push_back(cyc);
         end else
            check("idle_out", (inst_addr == 0 && inst_rdata == 0) ||
                  (inst_addr == exp_pc && inst_rdata == memf(exp_pc)), 1);
         if (!stop) begin
            if (br_taken) begin
               armed = 1'b1;
               tgt = br_target;
            end
            if (redir) begin
               exp_pc = exception ? EXC_PC : epc;
               armed = 1'b0;
            end else if (inst_data_ok) begin
               exp_pc = armed ? tgt : exp_pc + 32'd4;
               armed = 1'b0;
            end
         end
      end
      if (mem_data_ok) pend = 1'b0;
      else if (pend) lat--;
      if (!reset && inst_req && inst_addr_ok) begin
         pend = 1'b1;
         pend_addr = inst_req_addr;
         lat = $urandom_range(lat_max, lat_min);
         acc_q.push_back(inst_req_addr);
         acc_cyc.push_back(cyc);
      end
      cyc++;
      @(posedge clk);
      #1;
      br_taken = 1'b0;
      exception = 1'b0;
      eret = 1'b0;
   endtask
   task automatic run_got(input int n, input int budget);
      while (got_q.size() < n && budget > 0) begin
         step();
         budget--;
      end
      check("got_timeout", got_q.size() >= n, 1);
   endtask
   task automatic run_acc(input int n, input int budget);
      while (acc_q.size() < n && budget > 0) begin
         step();
         budget--;
      end
      check("acc_timeout", acc_q.size() >= n, 1);
   endtask
   initial begin
      int n, a, rel, b;
      logic [31:0] r;
      reset = 1'b1; stall = 1'b0; stop = 1'b0; exception = 1'b0; eret = 1'b0; br_taken = 1'b0;
      epc = 32'h0; br_target = 32'h0; inst_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
      step();
      step();
      reset = 1'b0;
      rel = cyc;
      run_got(1, 20);
      if (got_q.size() >= 1 && acc_cyc.size() >= 1) begin
         check("t1_addr", got_q[0], RESET_PC);
         check("t1_lat_acc", dok_cyc[0] - acc_cyc[0], 2);
         check("t1_lat_rel", dok_cyc[0] - rel, 3);
      end
      run_got(4, 30);
      for (int i = 1; i < 4 && i < got_q.size(); i++) begin
         check("t2_addr", got_q[i], RESET_PC + 32'(4 * i));
         check("t2_rate", dok_cyc[i] - dok_cyc[i-1], 3);
      end
      stall = 1'b1;
      step();
      step();
      repeat (5) begin
         check("t3_dok", inst_data_ok, 0);
         check("t3_addr", inst_addr, 32'hbfc00010);
         check("t3_rdata", inst_rdata, memf(32'hbfc00010));
         step();
      end
      stall = 1'b0;
      n = got_q.size();
      step();
      check("t3_fire", got_q.size(), n + 1);
      check("t3_fire_addr", got_q[$], 32'hbfc00010);
      lat_min = 3; lat_max = 3;
      eret = 1'b1; epc = 32'hbfc00004;
      step();
      b = 0;
      while (!(acc_q.size() > 0 && acc_q[$] == 32'hbfc00004) && b < 30) begin
         step();
         b++;
      end
      check("t4_req", acc_q[$], 32'hbfc00004);
      a = acc_q.size();
      n = got_q.size();
      exception = 1'b1;
      step();
      run_got(n + 1, 40);
      check("t4_deliver", got_q[$], EXC_PC);
      if (acc_q.size() > a) check("t4_next_req", acc_q[a], EXC_PC);
      lat_min = 0; lat_max = 0;
      eret = 1'b1; epc = 32'h00000010;
      step();
      b = 0;
      while (!(got_q.size() > 0 && got_q[$] == 32'h10) && b < 30) begin
         step();
         b++;
      end
      check("t5_branch_inst", got_q[$], 32'h10);
      br_taken = 1'b1; br_target = 32'h80000100;
      n = got_q.size();
      run_got(n + 2, 30);
      if (got_q.size() >= n + 2) begin
         check("t5_slot", got_q[n], 32'h14);
         check("t5_target", got_q[n+1], 32'h80000100);
      end
      lat_min = 1; lat_max = 1;
      run_acc(acc_q.size() + 1, 20);
      reset = 1'b1;
      n = got_q.size();
      repeat (4) step();
      check("t6_no_dok", got_q.size(), n);
      reset = 1'b0;
      a = acc_q.size();
      run_acc(a + 1, 20);
      check("t6_restart_req", acc_q[$], RESET_PC);
      run_got(n + 1, 20);
      check("t6_restart_dok", got_q[$], RESET_PC);
      ok_pct = 60; lat_min = 0; lat_max = 4;
      n = got_q.size();
      repeat (800) begin
         stall = $urandom_range(99) < 20;
         stop = $urandom_range(99) < 5;
         exception = $urandom_range(99) < 1;
         eret = $urandom_range(99) < 1;
         r = $urandom; r[1:0] = 2'b00; epc = r;
         br_taken = $urandom_range(99) < 3;
         r = $urandom; r[1:0] = 2'b00; br_target = r;
         step();
      end
      stall = 1'b0; stop = 1'b0;
      check("rand_progress", got_q.size() > n + 30, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
